regfile_access_ctrl: RTL and testbench

//   Sequences and shares the 32x32 register file of the RV32I single-cycle core.

---
 rtl/regfile_access_ctrl.sv | 129 ++++++++++++
 tb/tb_regfile_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Clears the 32x32 register file after reset, then shares its ports between the core and a
// debug requester. Define RF_BYPASS_EN to forward same-cycle core writeback data to the reads.
module regfile_access_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [ADDR_W-1:0] core_rs1,
  input  logic [ADDR_W-1:0] core_rs2,
  output logic [DATA_W-1:0] core_rdata1,
  output logic [DATA_W-1:0] core_rdata2,
  output logic              core_stall,
  output logic              init_done,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  typedef enum logic [1:0] {StClear, StRun, StDbg, StAck} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              init_done_q, init_done_d;

  logic core_wr_ok, dbg_wr_ok;

  // x0 is never written by the core or debug port; only the clear sequence touches it.
  assign core_wr_ok = core_we & (core_rd != '0);
  assign dbg_wr_ok  = dbg_wr & (dbg_addr != '0);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    dbg_rdata_d = dbg_rdata_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d     = StRun;
          clr_cnt_d   = '0;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        if (dbg_req) state_d = StDbg;
      end
      StDbg: begin
        dbg_rdata_d = dbg_wr ? dbg_wdata : rf_rdata1;
        state_d     = StAck;
      end
      StAck: begin
        state_d = StRun;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_cnt_q   <= '0;
      dbg_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      dbg_rdata_q <= dbg_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    rf_rs1     = core_rs1;
    rf_rs2     = core_rs2;
    rf_rd      = core_rd;
    rf_din     = core_wdata;
    rf_w_en    = core_wr_ok;
    core_stall = 1'b0;
    unique case (state_q)
      StClear: begin
        rf_w_en    = 1'b1;
        rf_rd      = clr_cnt_q;
        rf_din     = '0;
        core_stall = 1'b1;
      end
      StDbg: begin
        // Debug owns read port 1 and the write port; the core write is dropped this cycle.
        rf_rs1     = dbg_addr;
        rf_rd      = dbg_addr;
        rf_din     = dbg_wdata;
        rf_w_en    = dbg_wr_ok;
        core_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_ack   = (state_q == StAck);
  assign dbg_rdata = dbg_rdata_q;
  assign init_done = init_done_q;

`ifdef RF_BYPASS_EN
  logic byp_ok;
  assign byp_ok      = core_wr_ok & ((state_q == StRun) | (state_q == StAck));
  assign core_rdata1 = (byp_ok && (core_rd == core_rs1)) ? core_wdata : rf_rdata1;
  assign core_rdata2 = (byp_ok && (core_rd == core_rs2)) ? core_wdata : rf_rdata2;
`else
  assign core_rdata1 = rf_rdata1;
  assign core_rdata2 = rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: behavioural register-file model, directed
// scenarios with literal expectations, then randomized core/debug traffic with occasional resets.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_we;
  logic [4:0]  core_rd, core_rs1, core_rs2;
  logic [31:0] core_wdata, core_rdata1, core_rdata2;
  logic        core_stall, init_done;
  logic        dbg_req, dbg_wr, dbg_ack;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        rf_w_en;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_din, rf_rdata1, rf_rdata2;

  regfile_access_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_we     (core_we),
    .core_rd     (core_rd),
    .core_wdata  (core_wdata),
    .core_rs1    (core_rs1),
    .core_rs2    (core_rs2),
    .core_rdata1 (core_rdata1),
    .core_rdata2 (core_rdata2),
    .core_stall  (core_stall),
    .init_done   (init_done),
    .dbg_req     (dbg_req),
    .dbg_wr      (dbg_wr),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_ack     (dbg_ack),
    .dbg_rdata   (dbg_rdata),
    .rf_w_en     (rf_w_en),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rd       (rf_rd),
    .rf_din      (rf_din),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2)
  );

  always #5 clk = ~clk;

  // Stand-in for the Register_File: combinational reads, clocked write.
  logic [31:0] rf_mem [32] = '{default: 32'hDEAD_BEEF};
  assign rf_rdata1 = rf_mem[rf_rs1];
  assign rf_rdata2 = rf_mem[rf_rs2];
  always @(posedge clk) if (rf_w_en) rf_mem[rf_rd] <= rf_din;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: clear writes still owed, debug phase (0 idle, 1 access, 2 ack).
  logic [31:0] regs_m [32];
  int          clr_left;
  int          dbg_phase;
  bit          init_m;
  logic [31:0] dbg_rdata_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_left    <= 32;
      dbg_phase   <= 0;
      init_m      <= 1'b0;
      dbg_rdata_m <= '0;
    end else if (clr_left > 0) begin
      regs_m[32-clr_left] <= '0;
      clr_left            <= clr_left - 1;
      if (clr_left == 1) init_m <= 1'b1;
    end else if (dbg_phase == 1) begin
      if (dbg_wr && dbg_addr != 0) regs_m[dbg_addr] <= dbg_wdata;
      dbg_rdata_m <= dbg_wr ? dbg_wdata : regs_m[dbg_addr];
      dbg_phase   <= 2;
    end else begin
      if (core_we && core_rd != 0) regs_m[core_rd] <= core_wdata;
      dbg_phase <= (dbg_phase == 0 && dbg_req) ? 1 : 0;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] rs);
    logic [31:0] v;
    v = regs_m[rs];
`ifdef RF_BYPASS_EN
    if (core_we && core_rd != 0 && core_rd == rs) v = core_wdata;
`endif
    return v;
  endfunction

  logic exp_wen;

  always @(negedge clk) begin
    check("stall", core_stall, (clr_left > 0) || (dbg_phase == 1));
    check("init_done", init_done, init_m);
    check("dbg_ack", dbg_ack, dbg_phase == 2);
    check("dbg_rdata", dbg_rdata, dbg_rdata_m);
    if (clr_left > 0) begin
      check("clr_wen", rf_w_en, 1'b1);
      check("clr_rd", rf_rd, 32 - clr_left);
      check("clr_din", rf_din, 32'h0);
    end else if (dbg_phase == 1) begin
      exp_wen = dbg_wr && dbg_addr != 0;
      check("dbg_wen", rf_w_en, exp_wen);
      if (exp_wen) begin
        check("dbg_rd", rf_rd, dbg_addr);
        check("dbg_din", rf_din, dbg_wdata);
      end
    end else begin
      check("rdata1", core_rdata1, exp_read(core_rs1));
      check("rdata2", core_rdata2, exp_read(core_rs2));
      exp_wen = core_we && core_rd != 0;
      check("core_wen", rf_w_en, exp_wen);
      if (exp_wen) begin
        check("core_rd", rf_rd, core_rd);
        check("core_din", rf_din, core_wdata);
      end
    end
  end

  task automatic wait_init(output int n);
    n = 0;
    @(negedge clk);
    while (!init_done && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int n, stalls, ack_at, wait_cnt;
  logic [31:0] rdata_at_ack;

  initial begin
    rst_n = 1'b0; core_we = 1'b0; core_rd = '0; core_wdata = '0; core_rs1 = '0; core_rs2 = '0;
    dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    @(negedge clk);
    check("rst_wen", rf_w_en, 1'b1);
    check("rst_stall", core_stall, 1'b1);
    check("rst_ack", dbg_ack, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Clear takes exactly 32 cycles, then run.
    wait_init(n);
    check("t1_clear_len", n, 32);
    check("t1_stall_after", core_stall, 1'b0);

    // Core write then read back; x0 write blocked.
    next_cycle(); core_we = 1'b1; core_rd = 5'd1; core_wdata = 32'h4;
    next_cycle(); core_we = 1'b0; core_rs1 = 5'd1;
    @(negedge clk); check("t2_read_x1", core_rdata1, 32'h4);
    next_cycle(); core_we = 1'b1; core_rd = 5'd0; core_wdata = 32'hFFFF;
    @(negedge clk); check("t2_x0_wen", rf_w_en, 1'b0);
    next_cycle(); core_we = 1'b0; core_rs1 = 5'd0;
    @(negedge clk); check("t2_read_x0", core_rdata1, 32'h0);

    // Debug write alongside a core write; core write commits first.
    next_cycle(); core_we = 1'b1; core_rd = 5'd2; core_wdata = 32'h6;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h8;
    next_cycle(); core_we = 1'b0;
    @(negedge clk);
    check("t3_dbg_stall", core_stall, 1'b1);
    check("t3_dbg_rd", rf_rd, 5'd3);
    next_cycle(); core_rs1 = 5'd2; core_rs2 = 5'd3;
    @(negedge clk);
    check("t3_ack", dbg_ack, 1'b1);
    check("t3_ack_stall", core_stall, 1'b0);
    check("t3_reg2", core_rdata1, 32'h6);
    check("t3_reg3", core_rdata2, 32'h8);
    next_cycle(); dbg_req = 1'b0;

    // Debug read: ack two cycles after request, one stall cycle.
    next_cycle(); dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd3;
    stalls = 0; ack_at = 0; rdata_at_ack = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (core_stall) stalls++;
      if (dbg_ack) begin
        ack_at = k;
        rdata_at_ack = dbg_rdata;
        break;
      end
      next_cycle();
    end
    check("t4_ack_latency", ack_at, 3);
    check("t4_stall_cycles", stalls, 1);
    check("t4_rdata", rdata_at_ack, 32'h8);
    next_cycle(); dbg_req = 1'b0;

    // Same-cycle write/read of x5.
    next_cycle(); core_we = 1'b1; core_rd = 5'd5; core_wdata = 32'h1;
    next_cycle(); core_wdata = 32'h10; core_rs1 = 5'd5;
    @(negedge clk);
`ifdef RF_BYPASS_EN
    check("t6_bypass", core_rdata1, 32'h10);
`else
    check("t6_no_bypass", core_rdata1, 32'h1);
`endif
    next_cycle(); core_we = 1'b0;

    // Reset at clr_cnt==10 restarts a full clear.
    rst_n = 1'b0;
    next_cycle(); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t5_rd_restart", rf_rd, 5'd0);
    check("t5_init_low", init_done, 1'b0);
    next_cycle(); rst_n = 1'b1;
    wait_init(n);
    check("t5_clear_len", n, 32);

    // Random traffic; requester holds dbg_req until ack, drops it in the ack cycle.
    wait_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
      if (dbg_req) begin
        if (dbg_ack) dbg_req = 1'b0;
        else begin
          wait_cnt++;
          if (wait_cnt > 80) begin
            n_checks++;
            n_fail++;
            $display("FAIL dbg_ack_timeout: waited %0d cycles, required ack within 80", wait_cnt);
            dbg_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 5) == 0) begin
        dbg_req   = 1'b1;
        dbg_wr    = 1'($urandom_range(0, 1));
        dbg_addr  = 5'($urandom_range(0, 31));
        dbg_wdata = $urandom;
        wait_cnt  = 0;
      end
      core_we    = 1'($urandom_range(0, 1));
      core_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      core_wdata = $urandom;
      core_rs1   = ($urandom_range(0, 3) == 0) ? core_rd : 5'($urandom_range(0, 31));
      core_rs2   = 5'($urandom_range(0, 31));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
